// File: rtl/syn_sram_acc_ctrl_if.sv
// Pin-level bundle for the IS61LV25616 asynchronous SRAM on the DE1 board.
// mp is the controller side, sp the memory (or memory model) side.
interface syn_sram_mem_intf;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_LB_N;
  logic        SRAM_UB_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [15:0] SRAM_DO;
  logic [15:0] SRAM_DI;

  modport mp (
    output SRAM_ADDR, SRAM_LB_N, SRAM_UB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DO,
    input  SRAM_DI
  );

  modport sp (
    input  SRAM_ADDR, SRAM_LB_N, SRAM_UB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DO,
    output SRAM_DI
  );
endinterface

// File: rtl/syn_sram_acc_ctrl.sv
// Two-client round-robin SRAM controller: each grant runs one 16-bit access
// through SETUP / ACCESS (P_WAIT_CYCLES strobe cycles) / HOLD, all pins registered.
module syn_sram_acc_ctrl #(
  parameter int P_WAIT_CYCLES = 1
) (
  input  logic        clk_ir,
  input  logic        rst_ih,
  input  logic        cl0_req,
  input  logic        cl0_wr,
  input  logic [17:0] cl0_addr,
  input  logic [1:0]  cl0_be,
  input  logic [15:0] cl0_wdata,
  output logic        cl0_ack,
  output logic        cl0_rd_valid,
  output logic [15:0] cl0_rdata,
  input  logic        cl1_req,
  input  logic        cl1_wr,
  input  logic [17:0] cl1_addr,
  input  logic [1:0]  cl1_be,
  input  logic [15:0] cl1_wdata,
  output logic        cl1_ack,
  output logic        cl1_rd_valid,
  output logic [15:0] cl1_rdata,
  syn_sram_mem_intf.mp sram
);

  localparam int          NUM_CL   = 2;
  localparam logic [3:0]  CNT_LAST = 4'(P_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t state, state_nxt;

  logic [NUM_CL-1:0]        req, wr;
  logic [NUM_CL-1:0][17:0]  addr;
  logic [NUM_CL-1:0][1:0]   be;
  logic [NUM_CL-1:0][15:0]  wdata;

  logic [NUM_CL-1:0]        ack_q, rdv_q;
  logic [NUM_CL-1:0][15:0]  rdata_q;

  logic       last_gnt, gnt, gnt_nxt, start, lat_wr;
  logic [3:0] cnt;

  assign req   = {cl1_req,   cl0_req};
  assign wr    = {cl1_wr,    cl0_wr};
  assign addr  = {cl1_addr,  cl0_addr};
  assign be    = {cl1_be,    cl0_be};
  assign wdata = {cl1_wdata, cl0_wdata};

  assign cl0_ack      = ack_q[0];
  assign cl1_ack      = ack_q[1];
  assign cl0_rd_valid = rdv_q[0];
  assign cl1_rd_valid = rdv_q[1];
  assign cl0_rdata    = rdata_q[0];
  assign cl1_rdata    = rdata_q[1];

  // Under contention the client that did not win last time is granted.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    start     = 1'b0;
    case (state)
      IDLE: if (|req) begin
        start     = 1'b1;
        state_nxt = SETUP;
        gnt_nxt   = (&req) ? ~last_gnt : req[1];
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == CNT_LAST) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pins are driven from the transition into each state so they are valid
  // for the whole of that state's cycle.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      last_gnt       <= 1'b1;
      gnt            <= 1'b0;
      lat_wr         <= 1'b0;
      cnt            <= '0;
      ack_q          <= '0;
      rdv_q          <= '0;
      rdata_q        <= '0;
      sram.SRAM_ADDR <= '0;
      sram.SRAM_DO   <= '0;
      sram.SRAM_CE_N <= 1'b1;
      sram.SRAM_OE_N <= 1'b1;
      sram.SRAM_WE_N <= 1'b1;
      sram.SRAM_LB_N <= 1'b1;
      sram.SRAM_UB_N <= 1'b1;
    end else begin
      ack_q <= '0;
      rdv_q <= '0;
      gnt   <= gnt_nxt;
      if (start) begin
        last_gnt       <= gnt_nxt;
        lat_wr         <= wr[gnt_nxt];
        ack_q[gnt_nxt] <= 1'b1;
        sram.SRAM_CE_N <= 1'b0;
        sram.SRAM_ADDR <= addr[gnt_nxt];
        sram.SRAM_LB_N <= ~be[gnt_nxt][0];
        sram.SRAM_UB_N <= ~be[gnt_nxt][1];
        sram.SRAM_DO   <= wr[gnt_nxt] ? wdata[gnt_nxt] : 16'h0000;
      end
      if (state == SETUP) begin
        cnt            <= '0;
        sram.SRAM_OE_N <= lat_wr;
        sram.SRAM_WE_N <= ~lat_wr;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          sram.SRAM_OE_N <= 1'b1;
          sram.SRAM_WE_N <= 1'b1;
          if (!lat_wr) begin
            rdv_q[gnt]   <= 1'b1;
            rdata_q[gnt] <= sram.SRAM_DI;
          end
        end
      end
      if (state == HOLD) begin
        sram.SRAM_CE_N <= 1'b1;
        sram.SRAM_LB_N <= 1'b1;
        sram.SRAM_UB_N <= 1'b1;
      end
    end
  end

  p_wait_legal: assert property (@(posedge clk_ir)
    (P_WAIT_CYCLES >= 1) && (P_WAIT_CYCLES <= 15));

endmodule

// File: tb/tb_syn_sram_acc_ctrl.sv
// Directed bench: one controller with a 1-cycle strobe and one with a 3-cycle
// strobe, each driving a small behavioural SRAM.
module tb_syn_sram_acc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cl0_req = 0, cl0_wr = 0, cl1_req = 0, cl1_wr = 0;
  logic [17:0] cl0_addr = 0, cl1_addr = 0;
  logic [1:0]  cl0_be = 0, cl1_be = 0;
  logic [15:0] cl0_wdata = 0, cl1_wdata = 0;
  logic        cl0_ack, cl0_rd_valid, cl1_ack, cl1_rd_valid;
  logic [15:0] cl0_rdata, cl1_rdata;

  logic        d3_req = 0, d3_wr = 0, d3_zero = 0;
  logic [17:0] d3_addr = 0, d3_zaddr = 0;
  logic [1:0]  d3_be = 0, d3_zbe = 0;
  logic [15:0] d3_wdata = 0, d3_zwdata = 0;
  logic        d3_ack, d3_rd_valid, d3_ack1, d3_rd_valid1;
  logic [15:0] d3_rdata, d3_rdata1;

  syn_sram_mem_intf sram ();
  syn_sram_mem_intf sram3 ();

  syn_sram_acc_ctrl #(.P_WAIT_CYCLES(1)) u_dut (
    .clk_ir(clk), .rst_ih(rst),
    .cl0_req(cl0_req), .cl0_wr(cl0_wr), .cl0_addr(cl0_addr), .cl0_be(cl0_be),
    .cl0_wdata(cl0_wdata), .cl0_ack(cl0_ack), .cl0_rd_valid(cl0_rd_valid), .cl0_rdata(cl0_rdata),
    .cl1_req(cl1_req), .cl1_wr(cl1_wr), .cl1_addr(cl1_addr), .cl1_be(cl1_be),
    .cl1_wdata(cl1_wdata), .cl1_ack(cl1_ack), .cl1_rd_valid(cl1_rd_valid), .cl1_rdata(cl1_rdata),
    .sram(sram)
  );

  syn_sram_acc_ctrl #(.P_WAIT_CYCLES(3)) u_dut3 (
    .clk_ir(clk), .rst_ih(rst),
    .cl0_req(d3_req), .cl0_wr(d3_wr), .cl0_addr(d3_addr), .cl0_be(d3_be),
    .cl0_wdata(d3_wdata), .cl0_ack(d3_ack), .cl0_rd_valid(d3_rd_valid), .cl0_rdata(d3_rdata),
    .cl1_req(d3_zero), .cl1_wr(d3_zero), .cl1_addr(d3_zaddr), .cl1_be(d3_zbe),
    .cl1_wdata(d3_zwdata), .cl1_ack(d3_ack1), .cl1_rd_valid(d3_rd_valid1), .cl1_rdata(d3_rdata1),
    .sram(sram3)
  );

  // SRAM models: 256 words, indexed by the low address byte.
  logic [15:0] mem  [0:255];
  logic [15:0] mem3 [0:255];
  logic [3:0]  oe_cnt3 = 0;

  always @(posedge clk) begin
    if (!sram.SRAM_CE_N && !sram.SRAM_WE_N) begin
      if (!sram.SRAM_LB_N) mem[sram.SRAM_ADDR[7:0]][7:0]  <= sram.SRAM_DO[7:0];
      if (!sram.SRAM_UB_N) mem[sram.SRAM_ADDR[7:0]][15:8] <= sram.SRAM_DO[15:8];
    end
    if (!sram3.SRAM_CE_N && !sram3.SRAM_WE_N) begin
      if (!sram3.SRAM_LB_N) mem3[sram3.SRAM_ADDR[7:0]][7:0]  <= sram3.SRAM_DO[7:0];
      if (!sram3.SRAM_UB_N) mem3[sram3.SRAM_ADDR[7:0]][15:8] <= sram3.SRAM_DO[15:8];
    end
    oe_cnt3 <= sram3.SRAM_OE_N ? 4'd0 : oe_cnt3 + 4'd1;
  end

  assign sram.SRAM_DI  = (!sram.SRAM_CE_N && !sram.SRAM_OE_N) ? mem[sram.SRAM_ADDR[7:0]] : 16'h0000;
  // Valid data only in the third strobe cycle, so an early sample reads 0xDEAD.
  assign sram3.SRAM_DI = (!sram3.SRAM_CE_N && !sram3.SRAM_OE_N && oe_cnt3 == 4'd2)
                         ? mem3[sram3.SRAM_ADDR[7:0]] : 16'hDEAD;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_ce", 32'(sram.SRAM_CE_N), 1);
    chk("rst_oe", 32'(sram.SRAM_OE_N), 1);
    chk("rst_we", 32'(sram.SRAM_WE_N), 1);
    chk("rst_lbub", 32'({sram.SRAM_LB_N, sram.SRAM_UB_N}), 3);
    chk("rst_addr", 32'(sram.SRAM_ADDR), 0);
    chk("rst_do", 32'(sram.SRAM_DO), 0);
    chk("rst_ack", 32'({cl0_ack, cl1_ack, cl0_rd_valid, cl1_rd_valid}), 0);
    chk("rst_rdata", 32'({cl0_rdata, cl1_rdata}), 0);
    rst = 1'b0;
    tick();

    // Client 0 write 0xBEEF to 0x12345
    cl0_req = 1; cl0_wr = 1; cl0_addr = 18'h12345; cl0_be = 2'b11; cl0_wdata = 16'hBEEF;
    tick();
    chk("w_ack", 32'(cl0_ack), 1);
    chk("w_setup_ce", 32'(sram.SRAM_CE_N), 0);
    chk("w_setup_we", 32'(sram.SRAM_WE_N), 1);
    chk("w_setup_addr", 32'(sram.SRAM_ADDR), 32'h12345);
    chk("w_setup_do", 32'(sram.SRAM_DO), 32'hBEEF);
    cl0_req = 0;
    tick();
    chk("w_ack_pulse", 32'(cl0_ack), 0);
    chk("w_acc_we", 32'(sram.SRAM_WE_N), 0);
    chk("w_acc_oe", 32'(sram.SRAM_OE_N), 1);
    chk("w_acc_addr", 32'(sram.SRAM_ADDR), 32'h12345);
    chk("w_acc_do", 32'(sram.SRAM_DO), 32'hBEEF);
    tick();
    chk("w_hold_we", 32'(sram.SRAM_WE_N), 1);
    chk("w_hold_ce", 32'(sram.SRAM_CE_N), 0);
    chk("w_no_rdv", 32'(cl0_rd_valid), 0);
    tick();
    chk("w_idle_ce", 32'(sram.SRAM_CE_N), 1);

    // Client 0 read back
    cl0_req = 1; cl0_wr = 0;
    tick();
    chk("r_ack", 32'(cl0_ack), 1);
    chk("r_setup_do", 32'(sram.SRAM_DO), 0);
    cl0_req = 0;
    tick();
    chk("r_acc_oe", 32'(sram.SRAM_OE_N), 0);
    chk("r_acc_we", 32'(sram.SRAM_WE_N), 1);
    tick();
    chk("r_rdv", 32'(cl0_rd_valid), 1);
    chk("r_rdata", 32'(cl0_rdata), 32'hBEEF);
    chk("r_hold_oe", 32'(sram.SRAM_OE_N), 1);
    tick();
    chk("r_rdv_pulse", 32'(cl0_rd_valid), 0);
    chk("r_rdata_kept", 32'(cl0_rdata), 32'hBEEF);

    // Byte-masked write, lower byte only
    cl0_req = 1; cl0_wr = 1; cl0_be = 2'b01; cl0_wdata = 16'hAA55;
    tick();
    chk("bm_setup_lbub", 32'({sram.SRAM_LB_N, sram.SRAM_UB_N}), 32'b01);
    cl0_req = 0;
    tick();
    chk("bm_acc_lbub", 32'({sram.SRAM_LB_N, sram.SRAM_UB_N}), 32'b01);
    chk("bm_acc_we", 32'(sram.SRAM_WE_N), 0);
    tick();
    chk("bm_hold_lbub", 32'({sram.SRAM_LB_N, sram.SRAM_UB_N}), 32'b01);
    tick();
    cl0_req = 1; cl0_wr = 0; cl0_be = 2'b11;
    tick();
    cl0_req = 0;
    tick(); tick();
    chk("bm_rdv", 32'(cl0_rd_valid), 1);
    chk("bm_rdata", 32'(cl0_rdata), 32'hBE55);
    tick();

    // Client 1 back-to-back: write 0x20, read 0x20, read 0x12345
    cl1_req = 1; cl1_wr = 1; cl1_addr = 18'h00020; cl1_be = 2'b11; cl1_wdata = 16'h1234;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("b2b_ack1_c%0d", c), 32'(cl1_ack), 32'(c == 1 || c == 5 || c == 9));
      chk($sformatf("b2b_ack0_c%0d", c), 32'(cl0_ack), 0);
      chk($sformatf("b2b_rdv1_c%0d", c), 32'(cl1_rd_valid), 32'(c == 7 || c == 11));
      if (c == 7)  chk("b2b_rdata_a", 32'(cl1_rdata), 32'h1234);
      if (c == 11) chk("b2b_rdata_b", 32'(cl1_rdata), 32'hBE55);
      if (c == 1) cl1_wr = 0;
      if (c == 5) cl1_addr = 18'h12345;
      if (c == 9) cl1_req = 0;
    end

    // Continuous contention, 6 reads, client 0 first
    cl0_req = 1; cl0_wr = 0; cl0_addr = 18'h12345; cl0_be = 2'b11;
    cl1_req = 1; cl1_wr = 0; cl1_addr = 18'h00020; cl1_be = 2'b11;
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk($sformatf("rr_ack0_c%0d", c), 32'(cl0_ack), 32'(c % 4 == 1 && ((c - 1) / 4) % 2 == 0));
      chk($sformatf("rr_ack1_c%0d", c), 32'(cl1_ack), 32'(c % 4 == 1 && ((c - 1) / 4) % 2 == 1));
      chk($sformatf("rr_rdv0_c%0d", c), 32'(cl0_rd_valid), 32'(c % 4 == 3 && ((c - 3) / 4) % 2 == 0));
      chk($sformatf("rr_rdv1_c%0d", c), 32'(cl1_rd_valid), 32'(c % 4 == 3 && ((c - 3) / 4) % 2 == 1));
      if (c % 4 == 3) begin
        chk("rr_rdata0", 32'(cl0_rdata), 32'hBE55);
        if (c >= 7) chk("rr_rdata1", 32'(cl1_rdata), 32'h1234);
      end
      if (c == 17) cl0_req = 0;
      if (c == 21) cl1_req = 0;
    end

    // Reset during the ACCESS cycle of a write
    cl0_req = 1; cl0_wr = 1; cl0_addr = 18'h00040; cl0_wdata = 16'h7777;
    tick();
    chk("rm_ack", 32'(cl0_ack), 1);
    cl0_req = 0;
    tick();
    chk("rm_acc_we", 32'(sram.SRAM_WE_N), 0);
    rst = 1;
    tick();
    chk("rm_we", 32'(sram.SRAM_WE_N), 1);
    chk("rm_ce", 32'(sram.SRAM_CE_N), 1);
    chk("rm_addr", 32'(sram.SRAM_ADDR), 0);
    chk("rm_do", 32'(sram.SRAM_DO), 0);
    chk("rm_pulses", 32'({cl0_ack, cl1_ack, cl0_rd_valid, cl1_rd_valid}), 0);
    rst = 0;
    cl0_req = 1; cl0_wr = 0; cl0_addr = 18'h12345;
    cl1_req = 1; cl1_wr = 0; cl1_addr = 18'h00020;
    tick();
    chk("pr_ack0", 32'(cl0_ack), 1);
    chk("pr_ack1", 32'(cl1_ack), 0);
    chk("pr_addr", 32'(sram.SRAM_ADDR), 32'h12345);
    cl0_req = 0;
    tick(); tick();
    chk("pr_rdv0", 32'(cl0_rd_valid), 1);
    chk("pr_rdata0", 32'(cl0_rdata), 32'hBE55);
    tick(); tick();
    chk("pr_ack1_b", 32'(cl1_ack), 1);
    cl1_req = 0;
    tick(); tick();
    chk("pr_rdv1", 32'(cl1_rd_valid), 1);
    chk("pr_rdata1", 32'(cl1_rdata), 32'h1234);
    tick();

    // 3-cycle strobe: write then read of 0x33
    d3_req = 1; d3_wr = 1; d3_addr = 18'h00033; d3_be = 2'b11; d3_wdata = 16'h5A5A;
    tick();
    chk("p3_w_ack", 32'(d3_ack), 1);
    d3_req = 0;
    for (int c = 2; c <= 6; c++) tick();
    d3_req = 1; d3_wr = 0;
    tick();
    chk("p3_r_ack", 32'(d3_ack), 1);
    chk("p3_setup_oe", 32'(sram3.SRAM_OE_N), 1);
    d3_req = 0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("p3_oe_c%0d", c), 32'(sram3.SRAM_OE_N), 0);
      chk($sformatf("p3_rdv_c%0d", c), 32'(d3_rd_valid), 0);
    end
    tick();
    chk("p3_rdv", 32'(d3_rd_valid), 1);
    chk("p3_rdata", 32'(d3_rdata), 32'h5A5A);
    chk("p3_hold_oe", 32'(sram3.SRAM_OE_N), 1);
    chk("p3_hold_ce", 32'(sram3.SRAM_CE_N), 0);
    tick();
    chk("p3_idle_ce", 32'(sram3.SRAM_CE_N), 1);
    chk("p3_rdv_pulse", 32'(d3_rd_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/syn_sram_acc_ctrl.md
Name: syn_sram_acc_ctrl

Overview:
- Two-client SRAM access controller that drives the IS61LV25616 pin-level interface (mp modport of syn_sram_mem_intf) on the DE1 board.
- Round-robin arbitration between two requesters, e.g. a PCM buffer and a frame/FFT buffer.
- Each granted request becomes one 16-bit read or write, sequenced by a SETUP/ACCESS/HOLD FSM with a programmable strobe width.

Parameters:
P_WAIT_CYCLES, 1, width of the OE_N/WE_N strobe in clk_ir cycles; legal range 1..15.

Ports:
clk_ir  input  1  system clock.
rst_ih  input  1  synchronous, active-high reset.
cl0_req  input  1  client 0 request; held high until cl0_ack.
cl0_wr  input  1  client 0: 1 = write, 0 = read.
cl0_addr  input  18  client 0 word address.
cl0_be  input  2  client 0 byte enables; bit1 = upper, bit0 = lower.
cl0_wdata  input  16  client 0 write data.
cl0_ack  output  1  one-cycle pulse: client 0 request latched.
cl0_rd_valid  output  1  one-cycle pulse: cl0_rdata valid.
cl0_rdata  output  16  client 0 read data.
cl1_*  same set as cl0_* for client 1.
SRAM_ADDR  output  18  SRAM address.
SRAM_LB_N  output  1  SRAM lower-byte mask.
SRAM_UB_N  output  1  SRAM upper-byte mask.
SRAM_CE_N  output  1  SRAM chip enable.
SRAM_OE_N  output  1  SRAM output enable.
SRAM_WE_N  output  1  SRAM write enable.
SRAM_DO  output  16  SRAM write data.
SRAM_DI  input  16  SRAM read data.

Behaviour:
- All outputs are registered.
- Reset values:
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N = 1.
  - SRAM_ADDR = 0, SRAM_DO = 0.
  - clX_ack = 0, clX_rd_valid = 0, clX_rdata = 0.
  - FSM = IDLE; last_gnt = 1, so client 0 wins the first contention.
- FSM states: IDLE -> SETUP -> ACCESS (P_WAIT_CYCLES cycles) -> HOLD -> IDLE.
- IDLE:
  - If any req is high, grant one client.
    - Only one requesting: grant it.
    - Both requesting: grant the client that is not last_gnt.
  - Latch wr/addr/be/wdata; update last_gnt.
  - Next cycle: clX_ack = 1 for exactly one cycle, state = SETUP.
- SETUP:
  - SRAM_CE_N = 0; SRAM_ADDR = latched address.
  - SRAM_LB_N = ~be[0], SRAM_UB_N = ~be[1].
  - SRAM_DO = wdata for writes, 0 for reads.
  - SRAM_OE_N = SRAM_WE_N = 1.
- ACCESS:
  - Address, CE, LB/UB and DO held.
  - Read: SRAM_OE_N = 0. Write: SRAM_WE_N = 0.
  - A 4-bit counter runs 0..P_WAIT_CYCLES-1; at the terminal count the next state is HOLD.
  - Read: SRAM_DI is registered on the clock edge that ends the last ACCESS cycle.
- HOLD:
  - OE_N = WE_N = 1; CE_N still 0; address, byte masks and DO held.
  - Read: clX_rd_valid = 1 with clX_rdata = sampled data, for this cycle only.
  - Next state IDLE, where all SRAM strobes return to 1.
- Latency, P_WAIT_CYCLES = 1, request seen in cycle 0:
  - ack in cycle 1; OE_N/WE_N low in cycle 2; rd_valid in cycle 3; IDLE in cycle 4.
  - Back-to-back accesses therefore take 4 cycles each.
  - General period: 3 + P_WAIT_CYCLES cycles.
- Handshake rules:
  - A client must hold req and all qualifiers stable until ack; the block samples them only in IDLE.
  - A client must drop req, or present a new request, the cycle after ack. Because IDLE is at least 3 cycles after ack, no duplicate grant is possible.
  - clX_rdata holds its value until the next read for that client.
- Simultaneous requests: strict alternation under continuous contention (0,1,0,1...).
- be = 2'b00: the cycle still executes with both byte masks high. No data is transferred; ack and, for reads, rd_valid still occur.
- Reset mid-operation: on the cycle after rst_ih, all pins are at reset values. Any pending ack/rd_valid is suppressed, the transaction is dropped, and the FSM returns to IDLE.
- A P_WAIT_CYCLES value outside 1..15 is flagged by a simulation-only assertion.

Test Plan:
- Write then read, client 0 only, P_WAIT_CYCLES = 1:
  - Write addr 0x12345, data 0xBEEF, be 11 -> ack 1 cycle after req, WE_N low for exactly 1 cycle with ADDR = 0x12345 and DO = 0xBEEF.
  - Read of the same address with the SRAM model returning 0xBEEF -> rd_valid 3 cycles after req, rdata = 0xBEEF.
- Byte-masked write, be = 01, data 0xAA55 -> LB_N = 0, UB_N = 1 throughout SETUP..HOLD; read back returns upper byte unchanged, lower byte 0x55.
- Both clients hold req continuously for 6 transactions -> grant order 0,1,0,1,0,1; acks spaced 4 cycles apart; each rd_valid goes only to the owning client.
- P_WAIT_CYCLES = 3, read -> OE_N low for 3 consecutive cycles; DI sampled at the end of the third; rd_valid 5 cycles after req.
- rst_ih asserted during ACCESS of a write -> next cycle WE_N = CE_N = 1 and ADDR = 0; no rd_valid or ack; a new request after reset is acked normally, with client 0 winning contention.
- Single-client back-to-back: cl1 presents a new read the cycle after each ack -> one ack per 4 cycles, no duplicate acks, no missed requests.
